// File: rtl/sd_frame_rrarb_if.sv
// Frame-streaming bus bundle for the round-robin frame arbiter.
// The consumer-facing side carries one srdy/drdy handshake per requester
// plus frame delimiters. Requester i's data sits at c_data[i*width +: width].
// The producer-facing side carries the single arbitrated stream.
interface sd_frame_rrarb_if #(
    parameter int inputs = 4,
    parameter int width  = 8
);
    // Requester side
    logic [inputs-1:0]       c_srdy;
    logic [inputs-1:0]       c_fr_start;
    logic [inputs-1:0]       c_fr_end;
    logic [inputs*width-1:0] c_data;
    logic [inputs-1:0]       nc_drdy;

    // Downstream side
    logic                    np_srdy;
    logic                    np_fr_start;
    logic                    np_fr_end;
    logic [width-1:0]        np_data;
    logic                    p_drdy;

    // Arbiter view
    modport slave (
        input  c_srdy, c_fr_start, c_fr_end, c_data, p_drdy,
        output nc_drdy, np_srdy, np_fr_start, np_fr_end, np_data
    );

    // Environment view: drives the requesters and the downstream drain-ready
    modport master (
        output c_srdy, c_fr_start, c_fr_end, c_data, p_drdy,
        input  nc_drdy, np_srdy, np_fr_start, np_fr_end, np_data
    );
endinterface

// File: rtl/sd_frame_rrarb.sv
// Round-robin frame arbiter.
// A requester wins by presenting a start beat. Its whole frame is then
// forwarded downstream. If the first beat stalls longer than g_max_count
// cycles, the frame is dropped and sunk instead. Non-start beats that
// arrive from requesters that do not hold the grant are stray data and are
// discarded.
module sd_frame_rrarb #(
    parameter int inputs = 4,
    parameter int width  = 8,
    parameter int cnt_sz = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [cnt_sz-1:0] g_max_count,
    sd_frame_rrarb_if.slave   bus,
    output logic [inputs-1:0] grant,
    output logic              drop_pulse
);

    localparam int IW = (inputs > 1) ? $clog2(inputs) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no owner, arbitrating start beats
        WAIT = 2'd1,   // granted, first beat not yet accepted
        XFER = 2'd2,   // frame in flight downstream
        SINK = 2'd3    // frame being discarded after a timeout
    } state_t;

    state_t            state_q, state_d;
    logic [inputs-1:0] grant_q, grant_d;
    logic [IW-1:0]     gidx_q,  gidx_d;     // binary index of the grant owner
    logic [IW-1:0]     last_q,  last_d;     // last requester to finish a frame
    logic [cnt_sz-1:0] count_q, count_d;    // first-beat stall counter
    logic              drop_q,  drop_d;

    // Per-requester data lanes as an indexable array
    logic [width-1:0] lane_data [inputs];

    genvar gi;
    generate
        for (gi = 0; gi < inputs; gi++) begin : g_lane
            assign lane_data[gi] = bus.c_data[gi*width +: width];
        end
    endgenerate

    // Signals of the current grant owner
    logic             g_srdy;
    logic             g_start;
    logic             g_end;
    logic [width-1:0] g_data;

    assign g_srdy  = bus.c_srdy[gidx_q];
    assign g_start = bus.c_fr_start[gidx_q];
    assign g_end   = bus.c_fr_end[gidx_q];
    assign g_data  = lane_data[gidx_q];

    // Stray beats: valid but not a frame start. They are discarded, except
    // from the owner, whose beats are handled by the state machine.
    logic [inputs-1:0] stray;
    assign stray = bus.c_srdy & ~bus.c_fr_start;

    // Round-robin pick among requesters offering a start beat, nearest to last+1
    logic [inputs-1:0] cand;
    logic              rr_found;
    logic [IW-1:0]     rr_idx;
    logic [IW-1:0]     probe_idx;

    // Scan from the farthest offset down to the nearest; the nearest hit wins
    always_comb begin
        cand      = bus.c_srdy & bus.c_fr_start;
        rr_found  = 1'b0;
        rr_idx    = '0;
        probe_idx = '0;
        for (int k = inputs; k >= 1; k--) begin
            probe_idx = IW'((int'(last_q) + k) % inputs);
            if (cand[probe_idx]) begin
                rr_found = 1'b1;
                rr_idx   = probe_idx;
            end
        end
    end

    logic [inputs-1:0] nc_drdy_c;
    logic              np_srdy_c;
    logic              np_fr_start_c;
    logic              np_fr_end_c;
    logic              g_xfer;

    assign g_xfer = g_srdy & bus.p_drdy;

    // Next-state, grant bookkeeping and combinational handshake outputs
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        last_d        = last_q;
        count_d       = count_q;
        drop_d        = 1'b0;
        np_srdy_c     = 1'b0;
        np_fr_start_c = 1'b0;
        np_fr_end_c   = 1'b0;
        // grant_q is zero in IDLE, so this also covers "sink all strays" there
        nc_drdy_c     = stray & ~grant_q;

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d         = WAIT;
                    gidx_d          = rr_idx;
                    grant_d         = '0;
                    grant_d[rr_idx] = 1'b1;
                    count_d         = '0;
                end
            end

            WAIT: begin
                np_srdy_c         = g_srdy;
                np_fr_start_c     = g_start;
                np_fr_end_c       = g_end;
                nc_drdy_c[gidx_q] = bus.p_drdy;
                if (g_xfer) begin
                    if (g_end) begin
                        state_d = IDLE;
                        last_d  = gidx_q;
                        grant_d = '0;
                    end else begin
                        state_d = XFER;
                    end
                end else if (g_srdy) begin
                    // Downstream stalled on the first beat: count, then drop
                    if (count_q >= g_max_count) begin
                        nc_drdy_c[gidx_q] = 1'b1;
                        drop_d            = 1'b1;
                        if (g_end) begin
                            state_d = IDLE;
                            last_d  = gidx_q;
                            grant_d = '0;
                        end else begin
                            state_d = SINK;
                        end
                    end else if (count_q != {cnt_sz{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end

            XFER: begin
                // Once a frame is under way it is never dropped; stalls just hold
                np_srdy_c         = g_srdy;
                np_fr_start_c     = g_start;
                np_fr_end_c       = g_end;
                nc_drdy_c[gidx_q] = bus.p_drdy;
                if (g_xfer && g_end) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                end
            end

            SINK: begin
                nc_drdy_c[gidx_q] = 1'b1;
                if (g_srdy && g_end) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 first in line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(inputs - 1);
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.nc_drdy     = nc_drdy_c;
    assign bus.np_srdy     = np_srdy_c;
    assign bus.np_fr_start = np_fr_start_c;
    assign bus.np_fr_end   = np_fr_end_c;
    assign bus.np_data     = g_data;
    assign grant           = grant_q;
    assign drop_pulse      = drop_q;

endmodule

// File: tb/tb_sd_frame_rrarb.sv
// Directed bench for the round-robin frame arbiter (4 requesters, timeout 3).
module tb_sd_frame_rrarb;

    localparam int N = 4;
    localparam int W = 8;
    localparam int C = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [C-1:0] g_max_count;
    logic [N-1:0] grant;
    logic         drop_pulse;

    int checks = 0;
    int errors = 0;

    sd_frame_rrarb_if #(.inputs(N), .width(W)) bus ();

    sd_frame_rrarb #(.inputs(N), .width(W), .cnt_sz(C)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .g_max_count (g_max_count),
        .bus         (bus),
        .grant       (grant),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic srdy, input logic st, input logic en,
                         input logic [7:0] d);
        bus.c_srdy[i]         = srdy;
        bus.c_fr_start[i]     = st;
        bus.c_fr_end[i]       = en;
        bus.c_data[i*W +: W]  = d;
    endtask

    // Forward an n-beat frame from requester i with p_drdy=1, starting in WAIT
    task automatic send_frame(input int i, input int n, input logic [7:0] base,
                              input logic [N-1:0] exp_grant);
        logic [N-1:0] exp_drdy;
        exp_drdy    = '0;
        exp_drdy[i] = 1'b1;
        for (int b = 0; b < n; b++) begin
            drive(i, 1'b1, (b == 0), (b == n - 1), 8'(base + b));
            #1;
            $display("beat r%0d b%0d data=%0h grant=%b", i, b, bus.np_data, grant);
            chk($sformatf("grant r%0d b%0d", i, b), 32'(grant), 32'(exp_grant));
            chk($sformatf("np_srdy r%0d b%0d", i, b), 32'(bus.np_srdy), 32'd1);
            chk($sformatf("np_data r%0d b%0d", i, b), 32'(bus.np_data), 32'(8'(base + b)));
            chk($sformatf("np_fr_start r%0d b%0d", i, b), 32'(bus.np_fr_start), 32'(b == 0));
            chk($sformatf("np_fr_end r%0d b%0d", i, b), 32'(bus.np_fr_end), 32'(b == n - 1));
            chk($sformatf("nc_drdy r%0d b%0d", i, b), 32'(bus.nc_drdy), 32'(exp_drdy));
            tick();
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        g_max_count     = 3'd3;
        bus.c_srdy      = '0;
        bus.c_fr_start  = '0;
        bus.c_fr_end    = '0;
        bus.c_data      = '0;
        bus.p_drdy      = 1'b1;
        #1;
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset drop", 32'(drop_pulse), 32'd0);
        chk("reset np_srdy", 32'(bus.np_srdy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Fairness: requesters 0 and 2 alternate 3-beat frames
        drive(0, 1, 1, 0, 8'h10);
        drive(2, 1, 1, 0, 8'h20);
        #1;
        chk("fair idle grant", 32'(grant), 32'd0);
        chk("fair idle nc_drdy", 32'(bus.nc_drdy), 32'd0);
        chk("fair idle np_srdy", 32'(bus.np_srdy), 32'd0);
        tick();
        send_frame(0, 3, 8'h10, 4'b0001);
        drive(0, 1, 1, 0, 8'h13);
        #1;
        chk("fair gap1 grant", 32'(grant), 32'd0);
        chk("fair gap1 np_srdy", 32'(bus.np_srdy), 32'd0);
        tick();
        send_frame(2, 3, 8'h20, 4'b0100);
        drive(2, 1, 1, 0, 8'h23);
        #1;
        chk("fair gap2 grant", 32'(grant), 32'd0);
        tick();
        send_frame(0, 3, 8'h13, 4'b0001);
        drive(0, 0, 0, 0, 8'h00);
        #1;
        chk("fair gap3 grant", 32'(grant), 32'd0);
        tick();
        send_frame(2, 3, 8'h23, 4'b0100);
        drive(2, 0, 0, 0, 8'h00);

        // Single-beat frame from requester 1 (search starts at 3)
        drive(1, 1, 1, 1, 8'h31);
        #1;
        chk("single idle grant", 32'(grant), 32'd0);
        tick();
        $display("single beat grant=%b np_srdy=%b", grant, bus.np_srdy);
        chk("single grant", 32'(grant), 32'b0010);
        chk("single np_fr_start", 32'(bus.np_fr_start), 32'd1);
        chk("single np_fr_end", 32'(bus.np_fr_end), 32'd1);
        chk("single nc_drdy", 32'(bus.nc_drdy), 32'b0010);
        tick();
        drive(1, 0, 0, 0, 8'h00);
        #1;
        chk("single after grant", 32'(grant), 32'd0);
        chk("single after np_srdy", 32'(bus.np_srdy), 32'd0);

        // Drop: requester 3 stalls on its first beat
        bus.p_drdy = 1'b0;
        drive(3, 1, 1, 0, 8'h40);
        #1;
        tick();
        for (int s = 0; s < 3; s++) begin
            $display("drop stall %0d grant=%b nc_drdy=%b", s, grant, bus.nc_drdy);
            chk($sformatf("drop stall%0d grant", s), 32'(grant), 32'b1000);
            chk($sformatf("drop stall%0d nc_drdy", s), 32'(bus.nc_drdy), 32'd0);
            chk($sformatf("drop stall%0d np_srdy", s), 32'(bus.np_srdy), 32'd1);
            chk($sformatf("drop stall%0d pulse", s), 32'(drop_pulse), 32'd0);
            tick();
        end
        chk("drop sink nc_drdy", 32'(bus.nc_drdy), 32'b1000);
        chk("drop sink pulse early", 32'(drop_pulse), 32'd0);
        tick();
        drive(3, 1, 0, 0, 8'h41);
        #1;
        $display("drop pulse=%b np_srdy=%b", drop_pulse, bus.np_srdy);
        chk("drop pulse", 32'(drop_pulse), 32'd1);
        chk("drop sinkb1 np_srdy", 32'(bus.np_srdy), 32'd0);
        chk("drop sinkb1 nc_drdy", 32'(bus.nc_drdy), 32'b1000);
        chk("drop sinkb1 grant", 32'(grant), 32'b1000);
        tick();
        drive(3, 1, 0, 1, 8'h42);
        #1;
        chk("drop pulse gone", 32'(drop_pulse), 32'd0);
        chk("drop sinkb2 np_srdy", 32'(bus.np_srdy), 32'd0);
        chk("drop sinkb2 nc_drdy", 32'(bus.nc_drdy), 32'b1000);
        tick();
        drive(3, 0, 0, 0, 8'h00);
        bus.p_drdy = 1'b1;
        #1;
        chk("drop done grant", 32'(grant), 32'd0);

        // Mid-frame stall: 4-beat frame from requester 0, stalled 20 cycles at beat 3
        drive(0, 1, 1, 0, 8'h50);
        #1;
        tick();
        chk("stall grant", 32'(grant), 32'b0001);
        chk("stall b0 data", 32'(bus.np_data), 32'h50);
        tick();
        drive(0, 1, 0, 0, 8'h51);
        #1;
        chk("stall b1 data", 32'(bus.np_data), 32'h51);
        tick();
        drive(0, 1, 0, 0, 8'h52);
        bus.p_drdy = 1'b0;
        for (int s = 0; s < 20; s++) begin
            #1;
            chk($sformatf("stall c%0d nc_drdy", s), 32'(bus.nc_drdy), 32'd0);
            chk($sformatf("stall c%0d data", s), 32'(bus.np_data), 32'h52);
            tick();
        end
        chk("stall no drop", 32'(drop_pulse), 32'd0);
        chk("stall grant held", 32'(grant), 32'b0001);
        bus.p_drdy = 1'b1;
        #1;
        chk("stall resume nc_drdy", 32'(bus.nc_drdy), 32'b0001);
        chk("stall resume np_srdy", 32'(bus.np_srdy), 32'd1);
        tick();
        drive(0, 1, 0, 1, 8'h53);
        #1;
        $display("stall last beat data=%0h end=%b", bus.np_data, bus.np_fr_end);
        chk("stall b3 data", 32'(bus.np_data), 32'h53);
        chk("stall b3 end", 32'(bus.np_fr_end), 32'd1);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        #1;
        chk("stall done grant", 32'(grant), 32'd0);

        // Stray beat in IDLE is sunk immediately
        drive(2, 1, 0, 0, 8'h60);
        #1;
        $display("stray nc_drdy=%b", bus.nc_drdy);
        chk("stray nc_drdy", 32'(bus.nc_drdy), 32'b0100);
        chk("stray grant", 32'(grant), 32'd0);
        tick();
        drive(2, 0, 0, 0, 8'h00);
        #1;
        chk("stray no grant", 32'(grant), 32'd0);

        // Requester 0 asks while 3 is mid-frame: 3 finishes first
        drive(3, 1, 1, 0, 8'h70);
        #1;
        tick();
        chk("preempt grant3", 32'(grant), 32'b1000);
        chk("preempt b0 data", 32'(bus.np_data), 32'h70);
        tick();
        drive(3, 1, 0, 0, 8'h71);
        drive(0, 1, 1, 1, 8'h80);
        #1;
        chk("preempt held grant", 32'(grant), 32'b1000);
        chk("preempt nc_drdy", 32'(bus.nc_drdy), 32'b1000);
        chk("preempt b1 data", 32'(bus.np_data), 32'h71);
        tick();
        drive(3, 1, 0, 1, 8'h72);
        #1;
        chk("preempt b2 data", 32'(bus.np_data), 32'h72);
        tick();
        drive(3, 0, 0, 0, 8'h00);
        #1;
        chk("preempt idle grant", 32'(grant), 32'd0);
        tick();
        $display("preempt next grant=%b", grant);
        chk("preempt grant0", 32'(grant), 32'b0001);
        chk("preempt r0 data", 32'(bus.np_data), 32'h80);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        #1;
        chk("preempt done grant", 32'(grant), 32'd0);

        // Reset mid-XFER, then requester 0 wins a tie with 1
        drive(1, 1, 1, 0, 8'h90);
        #1;
        tick();
        chk("rst grant1", 32'(grant), 32'b0010);
        tick();
        drive(1, 1, 0, 0, 8'h91);
        #1;
        chk("rst xfer data", 32'(bus.np_data), 32'h91);
        reset_n = 1'b0;
        #1;
        $display("reset asserted grant=%b np_srdy=%b", grant, bus.np_srdy);
        chk("rst async grant", 32'(grant), 32'd0);
        chk("rst async np_srdy", 32'(bus.np_srdy), 32'd0);
        chk("rst async drop", 32'(drop_pulse), 32'd0);
        drive(1, 0, 0, 0, 8'h00);
        tick();
        tick();
        reset_n = 1'b1;
        drive(0, 1, 1, 1, 8'hA0);
        drive(1, 1, 1, 0, 8'hB0);
        #1;
        chk("rst tie idle", 32'(grant), 32'd0);
        tick();
        $display("tie after reset grant=%b", grant);
        chk("rst tie grant", 32'(grant), 32'b0001);
        chk("rst tie data", 32'(bus.np_data), 32'hA0);
        chk("rst tie drop", 32'(drop_pulse), 32'd0);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        #1;
        chk("rst tie done", 32'(grant), 32'd0);

        // Zero threshold: single-beat frame dropped on its first stalled cycle
        g_max_count = 3'd0;
        bus.p_drdy  = 1'b0;
        drive(2, 1, 1, 1, 8'hC0);
        #1;
        tick();
        chk("zero grant", 32'(grant), 32'b0100);
        chk("zero nc_drdy", 32'(bus.nc_drdy), 32'b0100);
        tick();
        drive(2, 0, 0, 0, 8'h00);
        #1;
        $display("zero-threshold drop=%b grant=%b", drop_pulse, grant);
        chk("zero pulse", 32'(drop_pulse), 32'd1);
        chk("zero grant cleared", 32'(grant), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
